// File: rtl/matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_scan_ctrl
//
// Free-running refresh sequencer for a 32x32 HUB75-style RGB panel.
// Pixel pairs are read from a double-buffered synchronous frame RAM.
// For each of the 16 row pairs the block does the following in turn:
//   - shifts 32 columns into the panel, two clocks per column;
//   - pulses the latch;
//   - optionally blanks for GAP cycles;
//   - enables the LEDs for ON_TIME cycles.
// The front/back buffer swap is only ever performed at a frame boundary.
//
// Every panel-facing output is registered. It reflects the state the
// sequencer occupied during the previous clock. This keeps led_clk, lat and
// oe glitch-free and cleanly separated from one another.
//
// Optional build macro: MATRIX_DIM_EN
//   Adds a 4-bit brightness input. It is sampled on entry to DISPLAY, and
//   oe is only driven low for the first (ON_TIME*brightness)>>4 cycles.
//
// Parameters
//   ON_TIME     clk cycles per row in DISPLAY (1..255)
//   GAP         blank clk cycles between latch and DISPLAY (0..15)
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   enable      level, refresh runs while high
//   fb_addr     frame RAM read address {front_buf, row[3:0], col[4:0]}
//   fb_rdata    {rgb1[2:0], rgb2[2:0]}, valid one clk after fb_addr
//   swap_req    level, buffer swap request, held until swap_ack
//   swap_ack    one-clk pulse when the swap is performed
//   front_buf   buffer currently displayed
//   frame_done  one-clk pulse at the end of the row 15 DISPLAY
//   busy        high whenever the sequencer is not idle
//   r1..b2      panel colour data
//   led_clk     panel shift clock
//   lat         panel latch, active high
//   oe          panel output enable, active low
//   a..d        panel row address
// ---------------------------------------------------------------------------
module matrix_scan_ctrl #(
    parameter int ON_TIME = 64,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic [9:0] fb_addr,
    input  logic [5:0] fb_rdata,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       front_buf,
    output logic       frame_done,
    output logic       busy,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       r2,
    output logic       g2,
    output logic       b2,
    output logic       led_clk,
    output logic       lat,
    output logic       oe,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
`ifdef MATRIX_DIM_EN
    ,
    input  logic [3:0] brightness
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_DISPLAY  = 3'd5;

    localparam logic [7:0] OnTime8 = 8'(ON_TIME);
    localparam logic [7:0] OnLast  = 8'(ON_TIME - 1);
    localparam logic [7:0] GapLast = 8'((GAP > 0) ? (GAP - 1) : 0);

    logic [2:0] state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic       phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic       front_q, front_d;
    logic       armed_q, armed_d;
    logic       ack_q, ack_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic [9:0] addr_q, addr_d;
    logic [5:0] rgb_q, rgb_d;
    logic       led_q, led_d;
    logic       lat_q, lat_d;
    logic       oe_q, oe_d;
    logic [3:0] panelRow_q, panelRow_d;
    logic [7:0] onLen;

`ifdef MATRIX_DIM_EN
    logic [7:0]  onLen_q, onLen_d;
    logic [11:0] dimProd;

    assign dimProd = {4'd0, OnTime8} * {8'd0, brightness};
    assign onLen   = onLen_q;
`else
    assign onLen   = OnTime8;
`endif

    // Next-state logic.
    // Data-path actions (rgb capture, address advance, shift clock) happen
    // on the edge that leaves the corresponding state. Because of this, the
    // synchronous RAM always has a full cycle to respond to the address it
    // was given.
    //
    // A swap request stays armed only until it has been acknowledged. A
    // request held high across several frames therefore swaps just once;
    // it must drop and be raised again before another swap can happen.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        front_d    = front_q;
        armed_d    = armed_q | ~swap_req;
        ack_d      = 1'b0;
        done_d     = 1'b0;
        addr_d     = addr_q;
        rgb_d      = rgb_q;
        led_d      = 1'b0;
        lat_d      = 1'b0;
        oe_d       = 1'b1;
        panelRow_d = panelRow_q;
`ifdef MATRIX_DIM_EN
        onLen_d    = onLen_q;
`endif

        case (state_q)
            S_IDLE: begin
                row_d   = 4'd0;
                col_d   = 5'd0;
                phase_d = 1'b0;
                addr_d  = {front_q, 4'd0, 5'd0};
                if (enable) begin
                    state_d = S_PREFETCH;
                end
            end

            S_PREFETCH: begin
                col_d   = 5'd0;
                phase_d = 1'b0;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                if (!phase_q) begin
                    rgb_d   = fb_rdata;
                    addr_d  = {front_q, row_q, col_q + 5'd1};
                    phase_d = 1'b1;
                end else begin
                    led_d   = 1'b1;
                    phase_d = 1'b0;
                    col_d   = col_q + 5'd1;
                    if (col_q == 5'd31) begin
                        state_d = S_LATCH;
                    end
                end
            end

            S_LATCH: begin
                lat_d      = 1'b1;
                panelRow_d = row_q;
                cnt_d      = 8'd0;
                if (GAP == 0) begin
                    state_d = S_DISPLAY;
                end else begin
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == GapLast) begin
                    cnt_d   = 8'd0;
                    state_d = S_DISPLAY;
                end
            end

            S_DISPLAY: begin
                oe_d  = (cnt_q < onLen) ? 1'b0 : 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == OnLast) begin
                    cnt_d = 8'd0;
                    if (!enable) begin
                        // Abandon the frame quietly; a restart begins at row 0.
                        row_d   = 4'd0;
                        state_d = S_IDLE;
                    end else if (row_q == 4'd15) begin
                        done_d  = 1'b1;
                        row_d   = 4'd0;
                        state_d = S_PREFETCH;
                        if (swap_req && armed_q) begin
                            front_d = ~front_q;
                            ack_d   = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = S_PREFETCH;
                    end
                    // The first fetch of the next row uses the new buffer.
                    addr_d = {front_d, row_d, 5'd0};
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MATRIX_DIM_EN
        // Brightness is frozen for the whole DISPLAY window.
        if (state_d == S_DISPLAY && state_q != S_DISPLAY) begin
            onLen_d = 8'(dimProd >> 4);
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            row_q      <= 4'd0;
            col_q      <= 5'd0;
            phase_q    <= 1'b0;
            cnt_q      <= 8'd0;
            front_q    <= 1'b0;
            armed_q    <= 1'b1;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= 10'd0;
            rgb_q      <= 6'd0;
            led_q      <= 1'b0;
            lat_q      <= 1'b0;
            oe_q       <= 1'b1;
            panelRow_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            front_q    <= front_d;
            armed_q    <= armed_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            rgb_q      <= rgb_d;
            led_q      <= led_d;
            lat_q      <= lat_d;
            oe_q       <= oe_d;
            panelRow_q <= panelRow_d;
        end
    end

`ifdef MATRIX_DIM_EN
    // Captured brightness window length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            onLen_q <= 8'd0;
        end else begin
            onLen_q <= onLen_d;
        end
    end
`endif

    assign fb_addr    = addr_q;
    assign swap_ack   = ack_q;
    assign front_buf  = front_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
    assign {r1, g1, b1, r2, g2, b2} = rgb_q;
    assign led_clk    = led_q;
    assign lat        = lat_q;
    assign oe         = oe_q;
    assign {d, c, b, a} = panelRow_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matrix_scan_ctrl
//
// Self-checking bench for matrix_scan_ctrl at default parameters. It uses a
// synchronous frame RAM model filled with an address-derived pattern.
// Cycle index k counts rising edges after the first edge that sees enable
// high (k = 0 is that edge), and outputs are sampled on the falling edge
// that follows.
// ---------------------------------------------------------------------------
module tb_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] fb_addr;
    logic [5:0] fb_rdata = 6'd0;
    logic       swap_req = 1'b0;
    logic       swap_ack, front_buf, frame_done, busy;
    logic       r1, g1, b1, r2, g2, b2;
    logic       led_clk, lat, oe, a, b, c, d;
`ifdef MATRIX_DIM_EN
    logic [3:0] brightness = 4'd15;
    localparam int ONLEN = 60;
    localparam int ROW1LEN = 0;
`else
    localparam int ONLEN = 64;
    localparam int ROW1LEN = 64;
`endif

    matrix_scan_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf),
        .frame_done(frame_done), .busy(busy),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .led_clk(led_clk), .lat(lat), .oe(oe),
        .a(a), .b(b), .c(c), .d(d)
`ifdef MATRIX_DIM_EN
        , .brightness(brightness)
`endif
    );

    always #5 clk = ~clk;

    // Frame RAM model: distinct, address-derived pixel data.
    logic [5:0] mem [1024];

    function automatic logic [5:0] pat(input int addr);
        return 6'((addr * 37 + 11) % 64);
    endfunction

    always @(posedge clk) fb_rdata <= mem[fb_addr];

    int cyc = 0;
    int base = 0;
    int tests = 0;
    int failures = 0;
    int ruleErr = 0;
    logic prevLed = 1'b0;
    logic [3:0] latRows[$];
    int fdK[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int curK();
        return cyc - base - 1;
    endfunction

    // Monitor: latch rows, frame_done times and panel timing rules.
    always @(negedge clk) begin
        if (lat) latRows.push_back({d, c, b, a});
        if (frame_done) fdK.push_back(curK());
        if (lat && led_clk) ruleErr++;
        if (lat && !oe) ruleErr++;
        if (led_clk !== prevLed && !oe) ruleErr++;
        prevLed = led_clk;
    end

    typedef struct {
        int         k;
        logic       led;
        logic       lat;
        logic       oe;
        logic       busy;
        logic [3:0] row;
        logic [9:0] addr;
        logic [5:0] rgb;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input int k, input logic l, input logic t,
                                input logic o, input logic bz,
                                input logic [3:0] r, input logic [9:0] ad,
                                input logic [5:0] rg);
        vec_t v;
        v.k = k; v.led = l; v.lat = t; v.oe = o; v.busy = bz;
        v.row = r; v.addr = ad; v.rgb = rg;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, curK());
        end
    endtask

    task automatic waitK(input int target);
        while (curK() < target) @(negedge clk);
    endtask

    // Raise enable on a falling edge; the next rising edge becomes k = 0.
    task automatic applyStimulus();
        enable = 1'b1;
        base = cyc;
    endtask

    task automatic countOeLow(input int from, input int to, output int n);
        n = 0;
        waitK(from);
        while (curK() <= to) begin
            if (!oe) n++;
            @(negedge clk);
        end
    endtask

    int n;
    int latIdx;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);

        vecs[0]  = mk(0,   0, 0, 1, 1, 0, 10'd0,  6'd0);
        vecs[1]  = mk(1,   0, 0, 1, 1, 0, 10'd0,  6'd0);
        vecs[2]  = mk(2,   0, 0, 1, 1, 0, 10'd1,  pat(0));
        vecs[3]  = mk(3,   1, 0, 1, 1, 0, 10'd1,  pat(0));
        vecs[4]  = mk(12,  0, 0, 1, 1, 0, 10'd6,  pat(5));
        vecs[5]  = mk(63,  1, 0, 1, 1, 0, 10'd31, pat(30));
        vecs[6]  = mk(64,  0, 0, 1, 1, 0, 10'd0,  pat(31));
        vecs[7]  = mk(65,  1, 0, 1, 1, 0, 10'd0,  pat(31));
        vecs[8]  = mk(66,  0, 1, 1, 1, 0, 10'd0,  pat(31));
        vecs[9]  = mk(67,  0, 0, 1, 1, 0, 10'd0,  pat(31));
        vecs[10] = mk(68,  0, 0, 0, 1, 0, 10'd0,  pat(31));
        vecs[11] = mk(131, 0, 0, (63 < ONLEN) ? 1'b0 : 1'b1, 1, 0, 10'd32, pat(31));
        vecs[12] = mk(132, 0, 0, 1, 1, 0, 10'd32, pat(31));
        vecs[13] = mk(134, 1, 0, 1, 1, 0, 10'd33, pat(32));
        vecs[14] = mk(197, 0, 1, 1, 1, 1, 10'd32, pat(63));

        // Reset state.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_oe", oe, 1);
        checkOutput("rst_lat", lat, 0);
        checkOutput("rst_led", led_clk, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_front", front_buf, 0);
        checkOutput("rst_addr", fb_addr, 0);
        checkOutput("rst_rgb", {r1, g1, b1, r2, g2, b2}, 0);
        checkOutput("rst_row", {d, c, b, a}, 0);

        // First row, cycle by cycle.
        applyStimulus();
        for (int i = 0; i < 15; i++) begin
            waitK(vecs[i].k);
            checkOutput($sformatf("v%0d_led", vecs[i].k), led_clk, vecs[i].led);
            checkOutput($sformatf("v%0d_lat", vecs[i].k), lat, vecs[i].lat);
            checkOutput($sformatf("v%0d_oe", vecs[i].k), oe, vecs[i].oe);
            checkOutput($sformatf("v%0d_busy", vecs[i].k), busy, vecs[i].busy);
            checkOutput($sformatf("v%0d_row", vecs[i].k), {d, c, b, a}, vecs[i].row);
            checkOutput($sformatf("v%0d_addr", vecs[i].k), fb_addr, vecs[i].addr);
            checkOutput($sformatf("v%0d_rgb", vecs[i].k), {r1, g1, b1, r2, g2, b2}, vecs[i].rgb);
        end

        // Full frame: rows in order, frame_done at 2096, wrap to row 0.
        waitK(2095);
        checkOutput("fd_before", frame_done, 0);
        waitK(2096);
        checkOutput("fd_at_2096", frame_done, 1);
        checkOutput("fd_addr_row0", fb_addr, 10'd0);
        waitK(2170);
        checkOutput("lat_count", latRows.size(), 17);
        for (int r = 0; r < 17 && r < latRows.size(); r++)
            checkOutput($sformatf("lat_row%0d", r), latRows[r], r % 16);

        // Swap requested mid-frame (row 7 of frame 2) waits for the frame end.
        waitK(2096 + 7 * 131 + 10);
        swap_req = 1'b1;
        waitK(4191);
        checkOutput("swap_front_hold", front_buf, 0);
        checkOutput("swap_ack_early", swap_ack, 0);
        waitK(4192);
        checkOutput("swap_ack", swap_ack, 1);
        checkOutput("swap_front", front_buf, 1);
        checkOutput("swap_fd", frame_done, 1);
        checkOutput("swap_addr", fb_addr, 10'd512);
        waitK(4193);
        checkOutput("swap_ack_pulse", swap_ack, 0);
        waitK(4192 + 12);
        checkOutput("swap_rgb_buf1", {r1, g1, b1, r2, g2, b2}, pat(517));
        // Held request: no second swap.
        waitK(6288);
        checkOutput("held_fd", frame_done, 1);
        checkOutput("held_no_ack", swap_ack, 0);
        checkOutput("held_front", front_buf, 1);
        waitK(6300);
        swap_req = 1'b0;
        waitK(6400);
        swap_req = 1'b1;
        waitK(8384);
        checkOutput("reswap_ack", swap_ack, 1);
        checkOutput("reswap_front", front_buf, 0);
        waitK(8390);
        swap_req = 1'b0;

        // enable dropped during SHIFT of row 3.
        waitK(8800);
        enable = 1'b0;
        waitK(8843);
        checkOutput("stop_lat", lat, 1);
        checkOutput("stop_row", {d, c, b, a}, 3);
        waitK(8910);
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_oe", oe, 1);
        waitK(8950);
        checkOutput("stop_fd_count", fdK.size(), 4);
        checkOutput("fd_k1", fdK.size() > 1 ? fdK[1] : -1, 4192);
        checkOutput("fd_k3", fdK.size() > 3 ? fdK[3] : -1, 8384);

        // Re-enable restarts at row 0.
        latIdx = latRows.size();
        applyStimulus();
        waitK(0);
        checkOutput("re_busy", busy, 1);
        checkOutput("re_addr", fb_addr, 10'd0);
        waitK(66);
        checkOutput("re_lat", lat, 1);
        checkOutput("re_row", {d, c, b, a}, 0);

        // Asynchronous reset during DISPLAY.
        waitK(100);
        checkOutput("pre_rst_oe", oe, 0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_oe", oe, 1);
        checkOutput("arst_lat", lat, 0);
        checkOutput("arst_led", led_clk, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_addr", fb_addr, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
`ifdef MATRIX_DIM_EN
        brightness = 4'd8;
`endif
        latIdx = latRows.size();
        applyStimulus();
        waitK(3);
        checkOutput("rs_led", led_clk, 1);
        countOeLow(60, 135, n);
        checkOutput("rs_oe_low_row0", n, (ONLEN == 60) ? 32 : 64);
        checkOutput("rs_lat_row0", latRows.size() > latIdx ? latRows[latIdx] : 4'hx, 0);
`ifdef MATRIX_DIM_EN
        brightness = 4'd0;
`endif
        countOeLow(131 + 60, 131 + 135, n);
        checkOutput("rs_oe_low_row1", n, ROW1LEN);
        checkOutput("rs_lat_row1", latRows.size() > latIdx + 1 ? latRows[latIdx + 1] : 4'hx, 1);

        checkOutput("panel_rules", ruleErr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
